// File: rtl/kuznechik_apb_fifo_wrapper.sv
// APB front end for the Kuznechik core: input/output block FIFOs plus an autonomous
// sequencer that runs the core request/ack handshake one block at a time.
module kuznechik_apb_fifo_wrapper #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned WAIT_STATES    = 0
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
    input  logic [31:0]               apb_pwdata_i,
    input  logic                      apb_pwrite_i,
    input  logic                      apb_psel_i,
    input  logic                      apb_penable_i,
    output logic [31:0]               apb_prdata_o,
    output logic                      apb_pready_o,
    output logic                      apb_pslverr_o,
    output logic                      core_rstn_o,
    output logic                      core_req_o,
    output logic                      core_ack_o,
    output logic [127:0]              core_data_o,
    input  logic                      core_busy_i,
    input  logic                      core_valid_i,
    input  logic [127:0]              core_data_i,
    output logic                      irq_o
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StAck} state_e;

    state_e        state_q, state_d;
    logic [2:0]    wait_cnt_q;
    logic          pready_q, irq_q, run_rst_q, en_q;
    logic [2:0]    irq_en_q, irq_stat_q, irq_stat_d;
    logic [31:0]   din_q [4];

    logic [127:0]  in_mem_q [FIFO_DEPTH];
    logic [PW-1:0] in_wr_q, in_rd_q;
    logic [CW-1:0] in_cnt_q;
    logic [127:0]  out_mem_q [FIFO_DEPTH];
    logic [PW-1:0] out_wr_q, out_rd_q;
    logic [CW-1:0] out_cnt_q;

    logic          access, commit, addr_ok, flush;
    logic          in_full, in_empty, out_empty;
    logic          in_push, in_pop, out_push, out_pop;
    logic [3:0]    idx, wr_din;
    logic [31:0]   rdata, status;
    logic [127:0]  out_head;
    logic          err, wr_ctrl, wr_irq_en, wr_irq_stat, push_req, pop_req, set_ovf, set_udf;

    assign access    = apb_psel_i & apb_penable_i;
    assign commit    = pready_q & access;
    assign idx       = apb_paddr_i[5:2];
    assign addr_ok   = (apb_paddr_i[APB_ADDR_WIDTH-1:6] == '0) && (apb_paddr_i[1:0] == 2'b00)
                       && (idx <= 4'd11);
    assign in_full   = (in_cnt_q == CW'(FIFO_DEPTH));
    assign in_empty  = (in_cnt_q == '0);
    assign out_empty = (out_cnt_q == '0);
    assign out_head  = out_mem_q[out_rd_q];
    assign status    = {21'b0, state_q != StIdle, out_empty, in_full, 4'(out_cnt_q), 4'(in_cnt_q)};

    // Side effects only land on the PREADY cycle; erroring accesses raise none of them.
    assign flush    = commit & wr_ctrl & ~apb_pwdata_i[0];
    assign in_push  = commit & push_req;
    assign in_pop   = (state_q == StReq);
    assign out_push = (state_q == StWait) & core_valid_i & ~flush;
    assign out_pop  = commit & pop_req;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wait_cnt_q <= '0;
            pready_q   <= 1'b0;
        end else if (pready_q) begin
            wait_cnt_q <= '0;
            pready_q   <= 1'b0;
        end else if (access) begin
            if (wait_cnt_q == 3'(WAIT_STATES)) pready_q <= 1'b1;
            else wait_cnt_q <= wait_cnt_q + 3'd1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    always_comb begin
        rdata       = '0;
        err         = 1'b0;
        wr_ctrl     = 1'b0;
        wr_irq_en   = 1'b0;
        wr_irq_stat = 1'b0;
        wr_din      = '0;
        push_req    = 1'b0;
        pop_req     = 1'b0;
        set_ovf     = 1'b0;
        set_udf     = 1'b0;
        if (!addr_ok) begin
            err = 1'b1;
        end else if (apb_pwrite_i) begin
            case (idx)
                4'd0:             wr_ctrl     = 1'b1;
                4'd2:             wr_irq_en   = 1'b1;
                4'd3:             wr_irq_stat = 1'b1;
                4'd4, 4'd5, 4'd6: wr_din[idx[1:0]] = 1'b1;
                4'd7: begin
                    if (in_full) begin
                        err     = 1'b1;
                        set_ovf = 1'b1;
                    end else begin
                        wr_din[3] = 1'b1;
                        push_req  = 1'b1;
                    end
                end
                default:          err = 1'b1;
            endcase
        end else begin
            case (idx)
                4'd0:                   rdata = {30'b0, en_q, run_rst_q};
                4'd1:                   rdata = status;
                4'd2:                   rdata = {29'b0, irq_en_q};
                4'd3:                   rdata = {29'b0, irq_stat_q};
                4'd4, 4'd5, 4'd6, 4'd7: rdata = din_q[idx[1:0]];
                default: begin
                    if (out_empty) begin
                        err     = 1'b1;
                        set_udf = 1'b1;
                    end else begin
                        rdata   = out_head[{idx[1:0], 5'b00000} +: 32];
                        pop_req = (idx == 4'd11);
                    end
                end
            endcase
        end
    end

    assign apb_pready_o  = pready_q;
    assign apb_prdata_o  = pready_q ? rdata : '0;
    assign apb_pslverr_o = pready_q & err;

    // Hardware set is OR-ed in after the W1C mask so it wins a same-cycle clear.
    always_comb begin
        irq_stat_d = irq_stat_q;
        if (commit && wr_irq_stat) irq_stat_d = irq_stat_d & ~apb_pwdata_i[2:0];
        irq_stat_d = irq_stat_d | {commit & set_udf, commit & set_ovf, out_push};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            run_rst_q  <= 1'b0;
            en_q       <= 1'b0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) din_q[i] <= '0;
        end else begin
            irq_stat_q <= irq_stat_d;
            irq_q      <= |(irq_stat_q & irq_en_q);
            if (commit && wr_ctrl) {en_q, run_rst_q} <= apb_pwdata_i[1:0];
            if (commit && wr_irq_en) irq_en_q <= apb_pwdata_i[2:0];
            for (int unsigned i = 0; i < 4; i++) begin
                if (commit && wr_din[i]) din_q[i] <= apb_pwdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            in_wr_q  <= '0;
            in_rd_q  <= '0;
            in_cnt_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) in_mem_q[i] <= '0;
        end else if (flush) begin
            in_wr_q  <= '0;
            in_rd_q  <= '0;
            in_cnt_q <= '0;
        end else begin
            if (in_push) begin
                in_mem_q[in_wr_q] <= {apb_pwdata_i, din_q[2], din_q[1], din_q[0]};
                in_wr_q           <= in_wr_q + PW'(1);
            end
            if (in_pop) in_rd_q <= in_rd_q + PW'(1);
            in_cnt_q <= in_cnt_q + CW'(in_push) - CW'(in_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) out_mem_q[i] <= '0;
        end else if (flush) begin
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (out_push) begin
                out_mem_q[out_wr_q] <= core_data_i;
                out_wr_q            <= out_wr_q + PW'(1);
            end
            if (out_pop) out_rd_q <= out_rd_q + PW'(1);
            out_cnt_q <= out_cnt_q + CW'(out_push) - CW'(out_pop);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en_q && run_rst_q && !in_empty && !core_busy_i &&
                    (out_cnt_q < CW'(FIFO_DEPTH))) begin
                    state_d = StReq;
                end
            end
            StReq:   state_d = StWait;
            StWait:  if (core_valid_i) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= StIdle;
        else         state_q <= state_d;
    end

    assign core_rstn_o = rstn_i & run_rst_q;
    assign core_req_o  = (state_q == StReq);
    assign core_ack_o  = (state_q == StAck);
    assign core_data_o = in_mem_q[in_rd_q];
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_kuznechik_apb_fifo_wrapper.sv
// Self-checking bench for kuznechik_apb_fifo_wrapper: stub cipher core, APB driver,
// and a queue scoreboard for randomized block traffic.
module tb_kuznechik_apb_fifo_wrapper;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WS    = 1;
    localparam logic [127:0] PT   = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT   = 128'h7f679d90bebc24305a468d42b9d4edcd;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic [AW-1:0] apb_paddr_i = '0;
    logic [31:0]   apb_pwdata_i = '0;
    logic          apb_pwrite_i = 1'b0;
    logic          apb_psel_i = 1'b0;
    logic          apb_penable_i = 1'b0;
    logic [31:0]   apb_prdata_o;
    logic          apb_pready_o, apb_pslverr_o;
    logic          core_rstn_o, core_req_o, core_ack_o, irq_o;
    logic [127:0]  core_data_o;
    logic          core_busy, core_valid;
    logic [127:0]  core_res;

    kuznechik_apb_fifo_wrapper #(
        .APB_ADDR_WIDTH(AW),
        .FIFO_DEPTH    (DEPTH),
        .WAIT_STATES   (WS)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .apb_paddr_i  (apb_paddr_i),
        .apb_pwdata_i (apb_pwdata_i),
        .apb_pwrite_i (apb_pwrite_i),
        .apb_psel_i   (apb_psel_i),
        .apb_penable_i(apb_penable_i),
        .apb_prdata_o (apb_prdata_o),
        .apb_pready_o (apb_pready_o),
        .apb_pslverr_o(apb_pslverr_o),
        .core_rstn_o  (core_rstn_o),
        .core_req_o   (core_req_o),
        .core_ack_o   (core_ack_o),
        .core_data_o  (core_data_o),
        .core_busy_i  (core_busy),
        .core_valid_i (core_valid),
        .core_data_i  (core_res),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Stand-in cipher: the GOST vector maps to its published ciphertext, anything else
    // to a cheap keyed permutation.
    function automatic logic [127:0] stub(input logic [127:0] x);
        if (x == PT) return CT;
        return {x[63:0], x[127:64]} ^ 128'h5a5a_1234_c3c3_0f0f_a5a5_9876_3c3c_f0f0;
    endfunction

    logic core_hold = 1'b0;
    int   ack_count = 0;
    int   lat;

    always @(negedge clk_i) begin
        if (!core_rstn_o) begin
            core_busy  <= 1'b0;
            core_valid <= 1'b0;
            core_res   <= '0;
        end else if (core_req_o) begin
            core_busy <= 1'b1;
            core_res  <= stub(core_data_o);
            lat       <= int'($urandom_range(1, 4));
        end else if (core_ack_o) begin
            core_busy  <= 1'b0;
            core_valid <= 1'b0;
            ack_count  <= ack_count + 1;
        end else if (core_busy && !core_valid && !core_hold) begin
            if (lat <= 1) core_valid <= 1'b1;
            else lat <= lat - 1;
        end
    end

    logic [31:0] rdat;
    logic        rerr;
    int          rcyc;

    task automatic apb(input logic w, input logic [AW-1:0] a, input logic [31:0] wd,
                       output logic [31:0] rd_o, output logic err_o, output int cyc);
        @(posedge clk_i); #1;
        apb_paddr_i   = a;
        apb_pwrite_i  = w;
        apb_pwdata_i  = wd;
        apb_psel_i    = 1'b1;
        apb_penable_i = 1'b0;
        @(posedge clk_i); #1;
        apb_penable_i = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk_i); #1;
            cyc++;
        end while (!apb_pready_o && cyc < 32);
        rd_o  = apb_prdata_o;
        err_o = apb_pslverr_o;
        @(posedge clk_i); #1;
        apb_psel_i    = 1'b0;
        apb_penable_i = 1'b0;
        apb_pwrite_i  = 1'b0;
        if (cyc >= 32) check("pready_timeout", 128'(cyc), 128'(WS + 1));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        apb(1'b1, a, d, rdat, rerr, rcyc);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        apb(1'b0, a, 32'h0, rdat, rerr, rcyc);
    endtask

    task automatic push_block(input logic [127:0] b);
        for (int w = 0; w < 4; w++) wr(AW'(16 + 4 * w), b[32*w +: 32]);
    endtask

    task automatic read_block(output logic [127:0] b, output logic e);
        e = 1'b0;
        for (int w = 0; w < 4; w++) begin
            rd(AW'(32 + 4 * w));
            b[32*w +: 32] = rdat;
            e = e | rerr;
        end
    endtask

    task automatic wait_out(input int n);
        int p = 0;
        do begin
            rd(AW'(4));
            p++;
        end while (!(rdat[7:4] == 4'(n) && !rdat[10]) && p < 100);
        check("wait_out_cnt", 128'(rdat[10:4]), 128'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] blk, got;
        logic [127:0] expq[$];
        logic [31:0]  din0_exp, din3_exp;
        logic         e;
        int           k;

        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;

        // Reset state
        check("rst_irq", 128'(irq_o), 0);
        check("rst_core_rstn", 128'(core_rstn_o), 0);
        check("rst_req_ack", 128'({core_req_o, core_ack_o}), 0);
        check("rst_core_data", core_data_o, 0);
        rd(AW'(0));
        check("rst_pready_cycles", 128'(rcyc), 128'(WS + 1));
        check("rst_pready_one_cycle", 128'(apb_pready_o), 0);
        check("rst_ctrl", 128'({rerr, rdat}), 0);
        for (int i = 1; i < 8; i++) begin
            rd(AW'(4 * i));
            check($sformatf("rst_reg_%0h", 4 * i), 128'({rerr, rdat}), (i == 1) ? 128'h200 : 0);
        end

        // GOST R 34.12 vector through the full path
        wr(AW'(0), 32'h3);
        push_block(PT);
        check("gost_push_err", 128'(rerr), 0);
        wait_out(1);
        read_block(got, e);
        check("gost_dout", got, CT);
        check("gost_dout_err", 128'(e), 0);
        rd(AW'(12));
        check("gost_irq_stat", 128'(rdat), 1);
        rd(AW'(4));
        check("gost_status_after_pop", 128'(rdat), 128'h200);
        wr(AW'(12), 32'h7);

        // Overflow with sequencer disabled
        wr(AW'(0), 32'h1);
        for (int i = 0; i <= int'(DEPTH); i++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            push_block(blk);
            if (i < int'(DEPTH)) check("ovf_push_ok", 128'(rerr), 0);
            else check("ovf_push_err", 128'(rerr), 1);
            if (i == int'(DEPTH) - 1) din3_exp = blk[127:96];
            if (i == int'(DEPTH)) din0_exp = blk[31:0];
        end
        rd(AW'(4));
        check("ovf_status", 128'(rdat), 128'(32'h300 | DEPTH));
        rd(AW'(12));
        check("ovf_irq_stat", 128'(rdat), 2);
        repeat (3) @(posedge clk_i);
        #1 check("ovf_irq_masked", 128'(irq_o), 0);
        wr(AW'(8), 32'h2);
        repeat (2) @(posedge clk_i);
        #1 check("ovf_irq_enabled", 128'(irq_o), 1);

        // Underflow and W1C
        rd(AW'(12'h2C));
        check("udf_err_data", 128'({rerr, rdat}), 128'h1_0000_0000);
        rd(AW'(12));
        check("udf_irq_stat", 128'(rdat), 6);
        check("udf_irq_high", 128'(irq_o), 1);
        wr(AW'(12), 32'h7);
        @(posedge clk_i);
        #1 check("w1c_irq_drop", 128'(irq_o), 0);
        rd(AW'(12));
        check("w1c_irq_stat", 128'(rdat), 0);

        // RUN_RST=0 while a block is in flight
        core_hold = 1'b1;
        k = ack_count;
        wr(AW'(0), 32'h3);
        rd(AW'(4));
        check("flush_wait_status", 128'(rdat), 128'(32'h600 | (DEPTH - 1)));
        wr(AW'(0), 32'h0);
        check("flush_core_rstn", 128'(core_rstn_o), 0);
        rd(AW'(4));
        check("flush_status", 128'(rdat), 128'h200);
        check("flush_no_ack", 128'(ack_count), 128'(k));
        rd(AW'(12'h10));
        check("flush_din0_kept", 128'({rerr, rdat}), 128'(din0_exp));
        rd(AW'(12'h1C));
        check("flush_din3_kept", 128'({rerr, rdat}), 128'(din3_exp));
        rd(AW'(8));
        check("flush_irq_en_kept", 128'(rdat), 2);
        core_hold = 1'b0;

        // Address and access errors
        rd(AW'(12'h34));
        check("err_unmapped", 128'(rerr), 1);
        wr(AW'(4), 32'hffff_ffff);
        check("err_wr_status", 128'(rerr), 1);
        rd(AW'(4));
        check("err_status_unchanged", 128'({rerr, rdat}), 128'h200);
        rd(AW'(12'h104));
        check("err_upper_addr", 128'(rerr), 1);
        wr(AW'(12'h20), 32'h1);
        check("err_wr_dout", 128'(rerr), 1);

        // Randomized traffic against a queue scoreboard
        wr(AW'(12), 32'h7);
        wr(AW'(0), 32'h3);
        for (int r = 0; r < 6; r++) begin
            k = int'($urandom_range(1, DEPTH));
            for (int j = 0; j < k; j++) begin
                blk = {$urandom, $urandom, $urandom, $urandom};
                expq.push_back(stub(blk));
                push_block(blk);
                check("rnd_push_err", 128'(rerr), 0);
            end
            wait_out(k);
            for (int j = 0; j < k; j++) begin
                read_block(got, e);
                check("rnd_dout", {got[127:1], got[0] ^ e}, expq.pop_front());
            end
            rd(AW'(12));
            check("rnd_done", 128'(rdat), 1);
            wr(AW'(12), 32'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
